vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

Sequencer for the VGA display path: owns the horizontal/vertical pixel counters, generates hsync/vsync/data-enable, and publishes the current pixel coordinate so the game renderer can supply a 3-bit colour. It also arbitrates access to game state by granting the game logic one update window per frame, confined to vertical blanking, so scene changes never tear mid-frame. It sits between the game logic/renderer and the VGA pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (line total 800)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (frame total 525)
- clk  in  1  pixel clock (25 MHz nominal)
- rst  in  1  synchronous, active-high reset
- pix_color_i  in  3  renderer colour for the pixel at (px, py)
- upd_req  in  1  game logic requests a state-update window
- upd_done  in  1  game logic finished its update (single-cycle pulse)
- px, py  out  10  current counter coordinate presented to the renderer
- color  out  3  registered pixel colour to the pins
- hsync, vsync  out  1  active-low sync
- de  out  1  active-video enable, aligned with color
- frame_start  out  1  one-cycle pulse when counters are at (0,0)
- upd_grant  out  1  update window open
- upd_abort  out  1  one-cycle pulse: window closed before upd_done

## Operation
- x counts 0..799, wraps to 0; y increments only when x==799, wraps 524->0 on the same cycle x wraps.
- px=x, py=y directly (registered counters).
- hsync low for x in [656,751]; vsync low for y in [490,491]; de=1 iff x<640 and y<480.
- color = pix_color_i when active, else 3'b000 (blanking forced black).
- vblank window: y>=480.
- Update FSM states:
  - IDLE: grant 0. upd_req and vblank -> GRANT; upd_req and not vblank -> WAIT.
  - WAIT: -> GRANT when vblank begins (y==480, x==0).
  - GRANT: grant 1. upd_done -> SPENT. End of frame (x==799, y==524) without upd_done -> pulse upd_abort, -> IDLE.
  - SPENT: grant 0; ignores upd_req; -> IDLE on the frame_start cycle.
- At most one grant per frame. upd_done outside GRANT is ignored.
- Simultaneous upd_done and end-of-frame: done wins, no abort, -> SPENT (leaves at next frame_start, i.e. immediately).
- upd_req dropped in WAIT -> IDLE.

## Timing
- Reset values: x=y=0, px=py=0, color=0, hsync=vsync=1, de=0, frame_start=0, upd_grant=0, upd_abort=0, FSM=IDLE.
- pix_color_i sampled the cycle px/py show a coordinate; color, de, hsync, vsync for that coordinate appear one cycle later (all four pipelined equally).
- frame_start is combinational-free: registered, high the cycle after counters reach (0,0), aligned with the color of pixel (0,0).
- upd_grant rises the cycle after the FSM transition condition; falls the cycle after upd_done.
- Reset mid-grant: grant low on the next edge, no abort pulse.

## Configuration
- VGA_TEST_PATTERN_EN defined: adds input pattern_sel (1 bit); when high, active-area colour is eight 80-pixel vertical bars by x (000,001,010,100,011,101,110,111) instead of pix_color_i; update arbitration unaffected.
- Undefined: no pattern_sel port, colour always from pix_color_i.

## Structure
- Package vga_pkg: timing parameters' default constants, derived totals (H_TOTAL=800, V_TOTAL=525), sync start/end constants, color_t (3-bit) typedef, update FSM state enum.
- One sub-module: vga_upd_arbiter (the update FSM), fed by vblank-start and end-of-frame strobes from the counter logic.

## Test plan
- Reset then run 420000 cycles -> frame_start every 420000 cycles, px wraps 799->0, py wraps 524->0.
- Check line 0 -> hsync low exactly cycles x=656..751 (+1 latency), de high for 640 cycles; vsync low lines 490-491 only.
- pix_color_i=3'b101 constant -> color=101 inside active area, 000 in blanking.
- upd_req at (100,100) -> grant rises at (1,480); upd_done at (10,485) -> grant falls next cycle; req held -> no second grant until next frame's vblank.
- upd_req in vblank, never done -> upd_abort pulse at (0,0) next frame, grant low; upd_done coincident with end-of-frame -> no abort.
- With VGA_TEST_PATTERN_EN, pattern_sel=1 -> color at x=0,80,...,560 equals 000,001,010,100,011,101,110,111; rst asserted during GRANT -> grant low next cycle, counters at 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg -- shared definitions for the VGA display path.
//
// Holds the default 640x480@60 timing constants, the derived line/frame
// totals and sync positions for those defaults, the 3-bit colour type,
// the update-window FSM state encoding and the test-pattern bar palette.
// The optional test pattern is controlled by VGA_TEST_PATTERN_EN (see
// vga_timing_ctrl).
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

    localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;                     // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;               // 751
    localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;                     // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;               // 491

    typedef logic [2:0] color_t;

    typedef enum logic [1:0] {
        UPD_IDLE,
        UPD_WAIT,
        UPD_GRANT,
        UPD_SPENT
    } upd_state_t;

    // Colour of vertical bar number idx (0 = leftmost).
    function automatic color_t bar_color(input int idx);
        case (idx)
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b010;
            3:       return 3'b100;
            4:       return 3'b011;
            5:       return 3'b101;
            6:       return 3'b110;
            7:       return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/vga_upd_arbiter.sv
// vga_upd_arbiter -- grants the game logic one state-update window per frame,
// confined to vertical blanking.
//
// Ports:
//   clk, rst      pixel clock, synchronous active-high reset
//   upd_req       game logic wants an update window
//   upd_done      game logic finished its update (single-cycle pulse)
//   vblank        counters are inside vertical blanking
//   vblank_start  counters are at the first blanking pixel (x=0, y=V_ACTIVE)
//   frame_end     counters are at the last pixel of the frame
//   frame_origin  counters are at (0,0)
//   upd_grant     window open
//   upd_abort     one-cycle pulse: window closed at frame end without upd_done
module vga_upd_arbiter
    import vga_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic upd_req,
    input  logic upd_done,
    input  logic vblank,
    input  logic vblank_start,
    input  logic frame_end,
    input  logic frame_origin,
    output logic upd_grant,
    output logic upd_abort
);

    upd_state_t state, state_nxt;
    logic       abort_q, abort_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= UPD_IDLE;
            abort_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            abort_q <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        abort_nxt = 1'b0;
        case (state)
            UPD_IDLE: begin
                // A request on the very last pixel would open a window that
                // spans the next frame's active video, so it waits instead.
                if (upd_req) begin
                    state_nxt = (vblank && !frame_end) ? UPD_GRANT : UPD_WAIT;
                end
            end
            UPD_WAIT: begin
                if (!upd_req) begin
                    state_nxt = UPD_IDLE;
                end else if (vblank_start) begin
                    state_nxt = UPD_GRANT;
                end
            end
            UPD_GRANT: begin
                // done wins over a coincident end of frame
                if (upd_done) begin
                    state_nxt = UPD_SPENT;
                end else if (frame_end) begin
                    state_nxt = UPD_IDLE;
                    abort_nxt = 1'b1;
                end
            end
            UPD_SPENT: begin
                if (frame_origin) begin
                    state_nxt = UPD_IDLE;
                end
            end
            default: state_nxt = UPD_IDLE;
        endcase
    end

    always_comb begin
        upd_grant = (state == UPD_GRANT);
        upd_abort = abort_q;
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl -- VGA display sequencer.
//
// Owns the pixel counters, generates hsync/vsync/de, presents the current
// coordinate to the renderer and registers the renderer's colour to the pins
// (black outside the active area). Also hosts the per-frame game-state update
// arbiter (vga_upd_arbiter).
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   pix_color_i [2:0]   renderer colour for the pixel at (px, py)
//   pattern_sel         (only with VGA_TEST_PATTERN_EN) show colour bars
//   upd_req, upd_done   game logic update handshake
//   px, py [9:0]        current counter coordinate
//   color [2:0]         registered pixel colour
//   hsync, vsync        active-low syncs, aligned with color
//   de                  active-video enable, aligned with color
//   frame_start         high with the colour of pixel (0,0)
//   upd_grant           update window open
//   upd_abort           window closed before upd_done (one-cycle pulse)
//
// Optional feature: define VGA_TEST_PATTERN_EN to add pattern_sel, which
// replaces the active-area colour with eight equal vertical bars.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] pix_color_i,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       pattern_sel,
`endif
    input  logic       upd_req,
    input  logic       upd_done,
    output logic [9:0] px,
    output logic [9:0] py,
    output logic [2:0] color,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       frame_start,
    output logic       upd_grant,
    output logic       upd_abort
);

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam int         BAR_W  = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    // Blanking forces black on the pins.
    function automatic color_t blank_color(input logic active, input color_t c);
        return active ? c : 3'b000;
    endfunction

    logic [9:0] x, y;
    logic       x_last, y_last, active, vblank;
    color_t     src_color;

    // Stage 0: counters
    always_comb begin
        x_last = (x == X_LAST);
        y_last = (y == Y_LAST);
        active = (x < X_ACT) && (y < Y_ACT);
        vblank = (y >= Y_ACT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (x_last) begin
            x <= '0;
            y <= y_last ? 10'd0 : y + 10'd1;
        end else begin
            x <= x + 10'd1;
        end
    end

    assign px = x;
    assign py = y;

`ifdef VGA_TEST_PATTERN_EN
    always_comb begin
        src_color = pattern_sel ? bar_color(int'(x) / BAR_W) : color_t'(pix_color_i);
    end
`else
    always_comb begin
        src_color = color_t'(pix_color_i);
    end
`endif

    // Stage 1: colour, syncs, enable and frame marker pipelined together
    color_t color_p1;
    logic   vld_p1, hsync_p1, vsync_p1, fs_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            color_p1 <= 3'b000;
            vld_p1   <= 1'b0;
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
            fs_p1    <= 1'b0;
        end else begin
            color_p1 <= blank_color(active, src_color);
            vld_p1   <= active;
            hsync_p1 <= !((x >= HS_LO) && (x <= HS_HI));
            vsync_p1 <= !((y >= VS_LO) && (y <= VS_HI));
            fs_p1    <= (x == 10'd0) && (y == 10'd0);
        end
    end

    assign color       = color_p1;
    assign de          = vld_p1;
    assign hsync       = hsync_p1;
    assign vsync       = vsync_p1;
    assign frame_start = fs_p1;

    vga_upd_arbiter u_arb (
        .clk          (clk),
        .rst          (rst),
        .upd_req      (upd_req),
        .upd_done     (upd_done),
        .vblank       (vblank),
        .vblank_start ((y == Y_ACT) && (x == 10'd0)),
        .frame_end    (x_last && y_last),
        .frame_origin ((x == 10'd0) && (y == 10'd0)),
        .upd_grant    (upd_grant),
        .upd_abort    (upd_abort)
    );

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl -- scoreboard bench for vga_timing_ctrl, run with a
// reduced 24x16 timing so several whole frames fit in a short run.
module tb_vga_timing_ctrl;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 10, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;  // 24
    localparam int VT = VA + VF + VS + VB;  // 16

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] pix_color_i = 3'b000;
    logic       pattern_sel = 1'b0;
    logic       upd_req = 1'b0;
    logic       upd_done = 1'b0;
    logic [9:0] px, py;
    logic [2:0] color;
    logic       hsync, vsync, de, frame_start, upd_grant, upd_abort;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_color_i (pix_color_i),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel (pattern_sel),
`endif
        .upd_req     (upd_req),
        .upd_done    (upd_done),
        .px          (px),
        .py          (py),
        .color       (color),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start),
        .upd_grant   (upd_grant),
        .upd_abort   (upd_abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] color;
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
    } pix_exp_t;

    pix_exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int mx = 0, my = 0, frame = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (frame %0d x=%0d y=%0d)",
                     tag, got, exp, frame, mx, my);
        end
    endtask

    // Update-window plan per frame, pos = y*HT + x of the counters.
    // f1: req from (5,5), granted (1,10), done at (10,12).
    // f2: req held, granted (1,10), never done -> abort at f3 (0,0).
    // f3: req at (3,11) inside vblank, done on the last pixel -> no abort.
    // f4: stray done, req dropped while waiting -> no grant.
    // f5: req at (1,11), reset while granted at (6,11).
    function automatic logic req_at(input int f, input int pos);
        return (f == 1 && pos >= 125) || (f == 2) ||
               (f == 3 && pos >= 267 && pos <= 270) ||
               (f == 4 && pos >= 60 && pos < 200) ||
               (f == 5 && pos >= 265);
    endfunction

    function automatic logic done_at(input int f, input int pos);
        return (f == 1 && pos == 298) || (f == 3 && pos == 383) || (f == 4 && pos == 50);
    endfunction

    function automatic logic exp_grant(input int f, input int pos);
        case (f)
            1:       return pos >= 241 && pos <= 298;
            2:       return pos >= 241;
            3:       return pos >= 268;
            5:       return pos >= 266 && pos <= 270;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic exp_abort(input int f, input int pos);
        return (f == 3 && pos == 0);
    endfunction

    task automatic one_cycle();
        int       pos;
        logic     act;
        pix_exp_t e;
        pos = my * HT + mx;
        chk("px", px, mx);
        chk("py", py, my);
        chk("upd_grant", upd_grant, exp_grant(frame, pos));
        chk("upd_abort", upd_abort, exp_abort(frame, pos));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("color", color, e.color);
            chk("de", de, e.de);
            chk("hsync", hsync, e.hs);
            chk("vsync", vsync, e.vs);
            chk("frame_start", frame_start, e.fs);
        end
        pix_color_i = (frame == 0) ? 3'b101 : 3'($urandom_range(0, 7));
        upd_req     = req_at(frame, pos);
        upd_done    = done_at(frame, pos);
        rst         = (frame == 5 && pos == 270);
        act     = (mx < HA) && (my < VA);
        e.color = act ? pix_color_i : 3'b000;
        e.de    = act;
        e.hs    = !(mx >= HA + HF && mx < HA + HF + HS);
        e.vs    = !(my >= VA + VF && my < VA + VF + VS);
        e.fs    = (mx == 0 && my == 0);
        sb.push_back(e);
        if (mx == HT - 1) begin
            mx = 0;
            if (my == VT - 1) begin
                my = 0;
                frame++;
            end else begin
                my++;
            end
        end else begin
            mx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_px"}, px, 0);
        chk({tag, "_py"}, py, 0);
        chk({tag, "_color"}, color, 0);
        chk({tag, "_hsync"}, hsync, 1);
        chk({tag, "_vsync"}, vsync, 1);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_upd_grant"}, upd_grant, 0);
        chk({tag, "_upd_abort"}, upd_abort, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b0;

        // frames 0..4, then frame 5 up to and including the reset request
        repeat (5 * HT * VT + 271) one_cycle();

        // reset landed mid-grant: everything back to reset values
        chk_reset_outputs("rst_mid_grant");
        rst      = 1'b0;
        upd_req  = 1'b0;
        sb.delete();
        mx       = 0;
        my       = 0;
        frame    = 6;
        repeat (2 * HT + 5) one_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
